// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//
// Bit-serial adder controller. Adds two WIDTH-bit operands plus a carry-in
// over WIDTH clock cycles, using one 1-bit adder slice. The slice is built from
// two half_adder cells and an OR gate. Operands are latched on the accepting
// edge and processed LSB-first. The result is presented as a registered
// sum/c_out pair.
//
// Handshake (valid/ready semantics):
//   - A request is "valid" when start=1.
//   - The block is "ready" only in IDLE.
//   - A transfer happens on a rising edge where start=1 and the block is IDLE.
//     a, b and c_in are captured on that edge only, and start is not queued.
//   - busy is high for the WIDTH cycles of RUN.
//   - done pulses for exactly one cycle when sum/c_out have just been loaded.
//   - busy and done are never high together.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset (clears the result too)
//   start  in   request, sampled only in IDLE
//   a, b   in   WIDTH-bit operands, sampled on the accepting edge
//   c_in   in   carry-in, sampled on the accepting edge
//   busy   out  high while the slice is being sequenced
//   done   out  one-cycle pulse, result just loaded
//   sum    out  WIDTH-bit registered result, held between operations
//   c_out  out  registered carry-out, held between operations
// -----------------------------------------------------------------------------

module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  // The bit counter needs clog2(WIDTH) bits, with a minimum of one bit so
  // that WIDTH=1 still has a legal vector.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Controller state. It is kept as a named enum so that it can be observed
  // hierarchically.
  state_t           state;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] p;
  logic             cy;
  logic [CW-1:0]    cnt;

  // Adder slice: two half adders plus an OR gate.
  logic             s0;
  logic             c0;
  logic             s1;
  logic             c1;
  logic             carry_next;
  logic [WIDTH-1:0] p_next;

  half_adder u_ha0 (
    .x (a_sh[0]),
    .y (b_sh[0]),
    .s (s0),
    .c (c0)
  );

  half_adder u_ha1 (
    .x (s0),
    .y (cy),
    .s (s1),
    .c (c1)
  );

  assign carry_next = c0 | c1;

  // The new sum bit enters at the MSB while P shifts right. Building the
  // shift this way avoids a P[WIDTH-1:1] slice, which does not exist when
  // WIDTH=1.
  assign p_next = WIDTH'({s1, p} >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      p     <= '0;
      cy    <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      c_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            cy    <= c_in;
            cnt   <= '0;
            p     <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end

        RUN: begin
          p    <= p_next;
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          cy   <= carry_next;
          cnt  <= cnt + CW'(1);
          // The final bit is processed on this edge. The result is taken
          // straight from the slice so that it is ready in the same cycle.
          if (cnt == LAST_BIT) begin
            sum   <= p_next;
            c_out <= carry_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
//
// Bench for serial_add_ctrl.
//
// It instantiates two copies of the design:
//   - dut  : WIDTH=8
//   - dut1 : WIDTH=1
//
// A transaction-level model of the 8-bit block predicts busy, done, sum and
// c_out from the request timeline. Results are computed as a+b+c_in with
// plain arithmetic and held in an expected queue. The model is compared
// against the DUT every cycle. Directed operations carry hand-computed
// literal results.
// -----------------------------------------------------------------------------

module tb_serial_add_ctrl;

  // ---------------------------------------------------------------------------
  // Clock and reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  // DUT signals and instances
  // ---------------------------------------------------------------------------
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       c_in;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       c_out;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       c_in1;
  logic       busy1;
  logic       done1;
  logic [0:0] sum1;
  logic       c_out1;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .c_in  (c_in1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .c_out (c_out1)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and check helper
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model for the WIDTH=8 instance
  //
  // ph = -1         : idle
  // ph = k (0..7)   : k edges after the accept edge, operation in flight
  // ph = 8          : result published, done cycle
  // ---------------------------------------------------------------------------
  localparam int W = 8;

  logic [8:0] exp_q[$];
  int         ph     = -1;
  logic [7:0] m_sum  = '0;
  logic       m_cout = 1'b0;
  logic [8:0] m_res;
  int         m_tot;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph     = -1;
      m_sum  = '0;
      m_cout = 1'b0;
      exp_q.delete();
    end else if (ph < 0) begin
      if (start) begin
        m_tot = int'(a) + int'(b) + int'(c_in);
        exp_q.push_back(9'(m_tot));
        ph = 0;
      end
    end else if (ph == W) begin
      ph = -1;
    end else begin
      ph++;
      if (ph == W) begin
        m_res = exp_q.pop_front();
        {m_cout, m_sum} = m_res;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare, sampled on the falling edge
  // ---------------------------------------------------------------------------
  bit   cmp_en     = 1'b0;
  bit   spacing_en = 1'b0;
  int   cyc        = 0;
  int   last_rise  = -1;
  int   rises      = 0;
  logic prev_busy  = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (cmp_en) begin
      check("busy",  32'(busy),  32'(ph >= 0 && ph < W));
      check("done",  32'(done),  32'(ph == W));
      check("sum",   32'(sum),   32'(m_sum));
      check("c_out", 32'(c_out), 32'(m_cout));
      check("busy_done_excl", 32'(busy & done), 32'd0);
      if (spacing_en && busy && !prev_busy) begin
        rises++;
        if (last_rise >= 0) check("accept_spacing", 32'(cyc - last_rise), 32'd10);
        last_rise = cyc;
      end
    end
    prev_busy = busy;
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------

  // Pulses start for one cycle with the given operands, then waits for done
  // within a bounded number of cycles. It then checks the literal result,
  // the busy length, and that the result is held afterwards.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                        input logic [7:0] es, input logic ec, input string tag);
    int n;
    int busy_cycles;
    n = 0;
    busy_cycles = 0;
    @(negedge clk);
    a = av; b = bv; c_in = cv; start = 1'b1;
    @(negedge clk);
    // Operand lines are scrambled after the accept; they must not matter.
    start = 1'b0;
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    c_in = 1'($urandom_range(0, 1));
    while (!done && n < 30) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      n++;
    end
    if (n >= 30) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done after %0d cycles, expected done within 30", tag, n);
    end else begin
      check({tag, "_sum"},   32'(sum),         32'(es));
      check({tag, "_c_out"}, 32'(c_out),       32'(ec));
      check({tag, "_busy_len"}, 32'(busy_cycles), 32'd8);
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(done),  32'd0);
      check({tag, "_sum_held"},   32'(sum),   32'(es));
      check({tag, "_cout_held"},  32'(c_out), 32'(ec));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0;
    start = 1'b0; a = '0; b = '0; c_in = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; c_in1 = 1'b0;
    cmp_en = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_sum",   32'(sum),   32'd0);
    check("rst_c_out", 32'(c_out), 32'd0);
    check("rst_sum1",  32'(sum1),  32'd0);
    rst_n = 1'b1;

    // Directed operations with hand-computed results
    run_op(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, "op_5a_33");
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "op_ff_01");
    run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "op_ff_ff_c");
    run_op(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, "op_00_00_c");

    // start held high with operands randomised every cycle
    @(negedge clk);
    spacing_en = 1'b1;
    last_rise = -1;
    rises = 0;
    start = 1'b1;
    for (int i = 0; i < 50; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      c_in = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    spacing_en = 1'b0;
    check("held_start_accepts", 32'(rises), 32'd5);

    // Reset in the middle of an operation, after bit 4 has been processed
    run_op(8'h7E, 8'h01, 1'b0, 8'h7F, 1'b0, "op_pre_reset");
    @(negedge clk);
    a = 8'hAA; b = 8'h55; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy",  32'(busy),  32'd0);
    check("midrst_done",  32'(done),  32'd0);
    check("midrst_sum",   32'(sum),   32'd0);
    check("midrst_c_out", 32'(c_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, "op_after_rst");

    // WIDTH=1 instance, exhaustive over a, b, c_in
    for (int v = 0; v < 8; v++) begin
      int tot;
      tot = v[0] + v[1] + v[2];
      @(negedge clk);
      a1 = 1'(v[0]); b1 = 1'(v[1]); c_in1 = 1'(v[2]); start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      check("w1_busy_run",  32'(busy1), 32'd1);
      check("w1_done_run",  32'(done1), 32'd0);
      @(negedge clk);
      check("w1_done",      32'(done1),  32'd1);
      check("w1_busy_done", 32'(busy1),  32'd0);
      check("w1_sum",       32'(sum1),   32'(tot & 1));
      check("w1_c_out",     32'(c_out1), 32'(tot >> 1));
      @(negedge clk);
      check("w1_done_clear", 32'(done1), 32'd0);
    end

    repeat (2) @(negedge clk);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got no end of stimulus by %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
